mac_n: RTL and testbench
========================

MAC_N -- requirements
Module: mac_n

Interface
REQ-001 Parameter N_CONN, default 8: number of synapse entries (2..64).
REQ-002 Parameter ADDR_W, default 12: source address width.
REQ-003 Parameter WEIGHT_W, default 16: signed two's-complement weight width.
REQ-004 Parameter ACC_W, default 24: signed accumulator and output width, at least WEIGHT_W + clog2(N_CONN).
REQ-005 Port: clock  in  1  single clock; all state updates on its rising edge.
REQ-006 Port: resetn  in  1  reset; asynchronous, active-low.
REQ-007 Port: cfg_we  in  1  entry write strobe.
REQ-008 Port: cfg_idx  in  clog2(N_CONN)  index of the entry to write.
REQ-009 Port: cfg_addr  in  ADDR_W  source address for the entry.
REQ-010 Port: cfg_weight  in  WEIGHT_W  signed weight for the entry.
REQ-011 Port: cfg_en  in  1  entry valid bit written with the entry.
REQ-012 Port: spike_valid  in  1  a spike is present on spike_addr this cycle.
REQ-013 Port: spike_addr  in  ADDR_W  source address of the incoming spike.
REQ-014 Port: timestep_end  in  1  single-cycle end-of-timestep pulse.
REQ-015 Port: busy  out  1  high in ACCUM and DONE.
REQ-016 Port: out_valid  out  1  single-cycle qualifier for out_sum.
REQ-017 Port: out_sum  out  ACC_W  signed weighted sum for the closed timestep.
REQ-018 Port: overrun  out  1  sticky flag: timestep_end was received while busy.

Function
REQ-019 The FSM SHALL have three states: COLLECT, ACCUM and DONE; COLLECT is the reset state.
REQ-020 In any state, spike_valid SHALL set incoming[i] for every enabled entry i whose address equals spike_addr; spikes with no matching entry SHALL be dropped silently.
REQ-021 Duplicate addresses across entries are legal; all matching bits SHALL be set.
REQ-022 In COLLECT, timestep_end SHALL copy incoming, including any spike in the same cycle, into snapshot, clear incoming, clear the accumulator, clear the index and enter ACCUM.
REQ-023 ACCUM SHALL last exactly N_CONN cycles; in the cycle for index k, the sign-extended weight[k] SHALL be added to the accumulator when snapshot[k] is set.
REQ-024 After index N_CONN-1 the FSM SHALL enter DONE for one cycle, assert out_valid and drive out_sum, then return to COLLECT.
REQ-025 out_valid SHALL be asserted N_CONN+1 cycles after the edge that samples timestep_end.
REQ-026 out_sum SHALL hold its value until the next DONE.
REQ-027 Spikes that arrive during ACCUM or DONE SHALL accumulate into incoming for the next timestep.
REQ-028 A timestep_end sampled in ACCUM or DONE SHALL be ignored and SHALL set overrun.
REQ-029 cfg_we SHALL be honoured only in COLLECT and SHALL be ignored while busy.
REQ-030 A configuration write SHALL take effect for spike matching from the next cycle.
REQ-031 An all-zero snapshot SHALL still run the full ACCUM sequence and SHALL produce out_sum = 0.

Reset
REQ-032 resetn low SHALL asynchronously force: state COLLECT, busy 0, out_valid 0, out_sum 0, overrun 0, incoming 0, snapshot 0, accumulator 0.
REQ-033 resetn low SHALL asynchronously clear every entry's enable bit, address and weight to 0.
REQ-034 A reset during ACCUM SHALL abort the sum with no out_valid pulse.

Configuration
REQ-035 With MAC_N_SATURATE_EN defined, any addition that overflows SHALL clamp the accumulator to the signed ACC_W maximum or minimum and hold it there for the rest of the timestep.
REQ-036 Without MAC_N_SATURATE_EN, additions SHALL wrap modulo 2^ACC_W.

Structure
REQ-037 Package mac_n_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-038 Sub-module mac_n_syn_table SHALL hold the entry storage and the parallel address comparators, and SHALL output a per-entry match vector and the weight at a selected index.

Verification
REQ-039 Scenario (N_CONN=4, entries {0:+10, 1:-3, 2:+7, 3:disabled @addr 5}): spikes on 0 and 2, then timestep_end -> out_valid 5 cycles later with out_sum = 17.
REQ-040 Scenario (same configuration): spike on address 1 in the same cycle as timestep_end -> out_sum = -3, and incoming is empty afterwards.
REQ-041 Scenario: spike on address 5, or on an unmapped address 9 -> out_sum = 0.
REQ-042 Scenario: spike on address 0 during ACCUM -> the current sum is unaffected; the next timestep's out_sum = 10. A timestep_end during ACCUM -> overrun = 1 and no extra out_valid.
REQ-043 Scenario (ACC_W=8, four entries of +100, all spiked): with MAC_N_SATURATE_EN -> out_sum = 127; without it -> out_sum = -112.
REQ-044 Scenario: resetn asserted mid-ACCUM -> all outputs 0 at once, no out_valid; cfg_we while busy -> table unchanged.

Source files
------------

// File: rtl/mac_n_pkg.sv
// mac_n_pkg: FSM state encoding and default parameters for mac_n.
package mac_n_pkg;
  typedef enum logic [1:0] {COLLECT, ACCUM, DONE} state_t;
  localparam int DEF_N_CONN = 8;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_WEIGHT_W = 16;
  localparam int DEF_ACC_W = 24;
endpackage

// File: rtl/mac_n_syn_table.sv
// mac_n_syn_table: synapse entry storage, parallel address match and weight read port.
module mac_n_syn_table
  import mac_n_pkg::*;
#(
  parameter int N_CONN = DEF_N_CONN,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  localparam int IDX_W = $clog2(N_CONN)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                we,
  input  logic [IDX_W-1:0]    idx,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [WEIGHT_W-1:0] weight,
  input  logic                en,
  input  logic [ADDR_W-1:0]   spike_addr,
  input  logic [IDX_W-1:0]    sel,
  output logic [N_CONN-1:0]   match,
  output logic [WEIGHT_W-1:0] weight_sel
);
  logic [N_CONN-1:0] en_q;
  logic [ADDR_W-1:0] addr_q [N_CONN];
  logic [WEIGHT_W-1:0] weight_q [N_CONN];
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      en_q <= '0;
      for (int i = 0; i < N_CONN; i++) begin
        addr_q[i] <= '0;
        weight_q[i] <= '0;
      end
    end else if (we) begin
      en_q[idx] <= en;
      addr_q[idx] <= addr;
      weight_q[idx] <= weight;
    end
  for (genvar g = 0; g < N_CONN; g++) begin : g_cmp
    assign match[g] = en_q[g] && addr_q[g] == spike_addr;
  end
  assign weight_sel = weight_q[sel];
endmodule

// File: rtl/mac_n.sv
// mac_n: spike-driven weighted sum over N_CONN synapses, one entry per ACCUM cycle.
// Define MAC_N_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module mac_n
  import mac_n_pkg::*;
#(
  parameter int N_CONN = DEF_N_CONN,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int ACC_W = DEF_ACC_W,
  localparam int IDX_W = $clog2(N_CONN)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [WEIGHT_W-1:0] cfg_weight,
  input  logic                cfg_en,
  input  logic                spike_valid,
  input  logic [ADDR_W-1:0]   spike_addr,
  input  logic                timestep_end,
  output logic                busy,
  output logic                out_valid,
  output logic [ACC_W-1:0]    out_sum,
  output logic                overrun
);
  state_t state, state_nx;
  logic [N_CONN-1:0] incoming, snapshot, match, hit;
  logic [IDX_W-1:0] idx;
  logic [WEIGHT_W-1:0] weight_sel;
  logic signed [ACC_W-1:0] acc, acc_nx, w_ext, sum;
  logic accept, last;
  mac_n_syn_table #(
    .N_CONN(N_CONN), .ADDR_W(ADDR_W), .WEIGHT_W(WEIGHT_W)
  ) u_table (
    .clock(clock), .resetn(resetn), .we(cfg_we && state == COLLECT),
    .idx(cfg_idx), .addr(cfg_addr), .weight(cfg_weight), .en(cfg_en),
    .spike_addr(spike_addr), .sel(idx), .match(match), .weight_sel(weight_sel)
  );
  assign hit = spike_valid ? match : '0;
  assign busy = state != COLLECT;
  assign accept = state == COLLECT && timestep_end;
  assign last = idx == IDX_W'(N_CONN - 1);
  assign w_ext = snapshot[idx] ? ACC_W'($signed(weight_sel)) : '0;
  assign sum = acc + w_ext;
`ifdef MAC_N_SATURATE_EN
  logic sat, ovf;
  assign ovf = acc[ACC_W-1] == w_ext[ACC_W-1] && sum[ACC_W-1] != acc[ACC_W-1];
  assign acc_nx = sat ? acc : !ovf ? sum :
                  acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  // once clamped, the accumulator stays pinned until the next timestep starts
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) sat <= 1'b0;
    else if (accept) sat <= 1'b0;
    else if (state == ACCUM && ovf) sat <= 1'b1;
`else
  assign acc_nx = sum;
`endif
  always_comb
    state_nx = state == COLLECT ? (timestep_end ? ACCUM : COLLECT) :
               state == ACCUM ? (last ? DONE : ACCUM) : COLLECT;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= COLLECT;
      incoming <= '0;
      snapshot <= '0;
      acc <= '0;
      idx <= '0;
      out_valid <= 1'b0;
      out_sum <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      incoming <= accept ? '0 : incoming | hit;
      out_valid <= state == DONE;
      if (accept) begin
        snapshot <= incoming | hit;
        acc <= '0;
        idx <= '0;
      end else if (state == ACCUM) begin
        acc <= acc_nx;
        idx <= idx + 1'b1;
      end
      if (state == DONE) out_sum <= acc;
      if (busy && timestep_end) overrun <= 1'b1;
    end
endmodule

// File: tb/tb_mac_n.sv
// tb_mac_n: directed scenarios against a cycle-level behavioural model of mac_n.
module tb_mac_n;
  localparam int N = 4;
  logic clock = 1'b0, resetn = 1'b0;
  logic cfg_we = 1'b0, cfg_en = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [11:0] cfg_addr = '0, spike_addr = '0;
  logic [7:0] cfg_weight = '0;
  logic spike_valid = 1'b0, timestep_end = 1'b0;
  logic busy, out_valid, overrun;
  logic [7:0] out_sum;
  int errors = 0, checks = 0;
  int m_addr [N], m_w [N];
  bit m_en [N], m_inc [N];
  int m_busy, m_sum, m_pend;
  bit m_ovr, m_ov;
  always #5 clock = ~clock;
  mac_n #(.N_CONN(N), .ADDR_W(12), .WEIGHT_W(8), .ACC_W(8)) dut (
    .clock(clock), .resetn(resetn), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_weight(cfg_weight), .cfg_en(cfg_en),
    .spike_valid(spike_valid), .spike_addr(spike_addr), .timestep_end(timestep_end),
    .busy(busy), .out_valid(out_valid), .out_sum(out_sum), .overrun(overrun)
  );
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_addr[i] = 0; m_w[i] = 0; m_en[i] = 0; m_inc[i] = 0;
    end
    m_busy = 0; m_sum = 0; m_pend = 0; m_ovr = 0; m_ov = 0;
  endtask
  function automatic int weighted(input bit snap [N]);
    int s = 0;
`ifdef MAC_N_SATURATE_EN
    bit held = 0;
    for (int k = 0; k < N; k++)
      if (snap[k] && !held) begin
        s += m_w[k];
        if (s > 127) begin s = 127; held = 1; end
        else if (s < -128) begin s = -128; held = 1; end
      end
`else
    for (int k = 0; k < N; k++) if (snap[k]) s += m_w[k];
    s = ((s + 128) % 256 + 256) % 256 - 128;
`endif
    return s;
  endfunction
  task automatic tick();
    bit hit [N];
    bit snap [N];
    @(posedge clock);
    for (int i = 0; i < N; i++) hit[i] = spike_valid && m_en[i] && m_addr[i] == int'(spike_addr);
    m_ov = 0;
    if (m_busy > 0) begin
      if (timestep_end) m_ovr = 1;
      m_busy--;
      if (m_busy == 0) begin m_ov = 1; m_sum = m_pend; end
      for (int i = 0; i < N; i++) m_inc[i] |= hit[i];
    end else begin
      if (timestep_end) begin
        for (int i = 0; i < N; i++) begin snap[i] = m_inc[i] | hit[i]; m_inc[i] = 0; end
        m_pend = weighted(snap);
        m_busy = N + 1;
      end else
        for (int i = 0; i < N; i++) m_inc[i] |= hit[i];
      if (cfg_we) begin
        m_en[cfg_idx] = cfg_en; m_addr[cfg_idx] = int'(cfg_addr); m_w[cfg_idx] = $signed(cfg_weight);
      end
    end
    #1;
    check("out_valid", int'(out_valid), int'(m_ov));
    check("busy", int'(busy), int'(m_busy > 0));
    check("overrun", int'(overrun), int'(m_ovr));
    check("out_sum", $signed(out_sum), m_sum);
    spike_valid = 0; timestep_end = 0; cfg_we = 0;
  endtask
  task automatic spike(input int a);
    spike_valid = 1; spike_addr = 12'(a); tick();
  endtask
  task automatic tend();
    timestep_end = 1; tick();
  endtask
  task automatic cfg(input int i, input int a, input int w, input bit e);
    cfg_we = 1; cfg_idx = 2'(i); cfg_addr = 12'(a); cfg_weight = 8'(w); cfg_en = e; tick();
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask
  task automatic close_ts();
    tend(); idle(N + 1);
    check("latency", int'(out_valid), 1);
  endtask
  task automatic pin(input string name, input int lit);
    check({name, "_dut"}, $signed(out_sum), lit);
    check({name, "_model"}, m_sum, lit);
  endtask
  task automatic zero_outputs(input string name);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_valid"}, int'(out_valid), 0);
    check({name, "_sum"}, int'(out_sum), 0);
    check({name, "_ovr"}, int'(overrun), 0);
  endtask
  initial begin
    model_reset();
    #2 zero_outputs("reset");
    #20 resetn = 1;
    cfg(0, 0, 10, 1); cfg(1, 1, -3, 1); cfg(2, 2, 7, 1); cfg(3, 5, 20, 0);
    spike(0); spike(2); close_ts(); pin("sum17", 17);
    spike_valid = 1; spike_addr = 12'd1; close_ts(); pin("same_cycle", -3);
    close_ts(); pin("cleared", 0);
    spike(5); spike(9); close_ts(); pin("unmapped", 0);
    tend(); spike(0); tend(); cfg(0, 0, 50, 1); idle(2);
    check("accum_valid", int'(out_valid), 1);
    pin("accum_spike", 0);
    check("overrun_set", int'(overrun), 1);
    idle(3);
    close_ts(); pin("next_ts", 10);
    for (int i = 0; i < N; i++) cfg(i, 7, 100, 1);
    spike(7);
`ifdef MAC_N_SATURATE_EN
    close_ts(); pin("saturate", 127);
`else
    close_ts(); pin("wrap", -112);
`endif
    spike(7); tend(); idle(2);
    #3 resetn = 0;
    #1 zero_outputs("midreset");
    model_reset();
    #2 resetn = 1;
    idle(N + 2);
    spike(7); close_ts(); pin("table_cleared", 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
